// File: rtl/pc_unit.sv
// Fetch-stage PC generator: F-stage PC register, next-PC mux, fetch-window fault
// check and a one-entry pending-redirect buffer for redirects seen during f_hold.
module pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
  parameter logic [31:0] IMEM_BASE = 32'h0000_3000,
  parameter logic [31:0] IMEM_SIZE = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_stall,
  input  logic        f_hold,
  input  logic        exc_req,
  input  logic [2:0]  npc_op,
  input  logic        br_taken,
  input  logic [31:0] d_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs,
  input  logic [31:0] epc,
  output logic [31:0] f_pc,
  output logic [31:0] npc,
  output logic        f_adel,
  output logic        pend
);

  localparam logic [2:0] OP_PC4  = 3'd0;
  localparam logic [2:0] OP_BR   = 3'd1;
  localparam logic [2:0] OP_J    = 3'd2;
  localparam logic [2:0] OP_JR   = 3'd3;
  localparam logic [2:0] OP_ERET = 3'd4;

  logic [31:0] pc4;
  logic [31:0] br_tgt;
  logic        redirect;
  logic [31:0] pend_pc;
  logic [31:0] pc_nxt;
  logic        pc_we;
  logic        pend_nxt;
  logic [31:0] pend_pc_nxt;

  // Window bounds are compared in 33 bits so BASE+SIZE cannot wrap to zero.
  function automatic logic fetch_fault(input logic [31:0] addr);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, IMEM_BASE};
    hi = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};
    return (addr[1:0] != 2'b00) || (a < lo) || (a >= hi);
  endfunction

  assign pc4    = f_pc + 32'd4;
  assign br_tgt = f_pc + {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    npc      = pc4;
    redirect = 1'b0;
    case (npc_op)
      OP_BR: begin
        npc      = br_taken ? br_tgt : pc4;
        redirect = br_taken;
      end
      OP_J: begin
        npc      = {d_pc[31:28], imm26, 2'b00};
        redirect = 1'b1;
      end
      OP_JR: begin
        npc      = rs;
        redirect = 1'b1;
      end
      OP_ERET: begin
        npc      = epc;
        redirect = 1'b1;
      end
      default: begin
        npc      = pc4;
        redirect = 1'b0;
      end
    endcase
  end

  // Priority: exception, hazard stall, fetch hold, live redirect, buffered redirect.
  always_comb begin
    pc_we       = 1'b0;
    pc_nxt      = npc;
    pend_nxt    = pend;
    pend_pc_nxt = pend_pc;
    if (exc_req) begin
      pc_we    = 1'b1;
      pc_nxt   = EXC_VEC;
      pend_nxt = 1'b0;
    end else if (d_stall) begin
      pc_we = 1'b0;
    end else if (f_hold) begin
      if (redirect) begin
        pend_pc_nxt = npc;
        pend_nxt    = 1'b1;
      end
    end else if (redirect) begin
      pc_we    = 1'b1;
      pc_nxt   = npc;
      pend_nxt = 1'b0;
    end else if (pend) begin
      pc_we    = 1'b1;
      pc_nxt   = pend_pc;
      pend_nxt = 1'b0;
    end else begin
      pc_we = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_pc    <= RESET_PC;
      f_adel  <= fetch_fault(RESET_PC);
      pend    <= 1'b0;
      pend_pc <= '0;
    end else begin
      if (pc_we) begin
        f_pc   <= pc_nxt;
        f_adel <= fetch_fault(pc_nxt);
      end
      pend    <= pend_nxt;
      pend_pc <= pend_pc_nxt;
    end
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Fetch-stage PC generator for the pipelined MIPS core: holds the F-stage PC register and computes the next PC.
- Next PC is computed from D-stage control (sequential, branch, j/jal, jr, eret), an exception request and two stall sources.
- Adds over the previous NPC logic: a parametrised reset/exception vector, an instruction-window fetch-fault check, and a one-entry pending-redirect buffer. The buffer keeps a D-stage redirect alive while the fetch side is held.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VEC, 32'h0000_4180, exception handler entry address.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_SIZE, 32'h0000_4000, byte size of the legal fetch window; legal range is [IMEM_BASE, IMEM_BASE+IMEM_SIZE).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- d_stall  in  1  hazard stall; freezes F and D.
- f_hold  in  1  fetch wait; freezes F only, D keeps advancing.
- exc_req  in  1  exception/interrupt taken this cycle.
- npc_op  in  3  0=PC4, 1=BR, 2=J (j/jal), 3=JR, 4=ERET; 5-7 are treated as PC4.
- br_taken  in  1  branch condition result from D.
- d_pc  in  32  PC of the D-stage instruction.
- imm16  in  16  branch offset.
- imm26  in  26  jump index.
- rs  in  32  forwarded GPR[rs] for JR.
- epc  in  32  CP0 EPC for ERET.
- f_pc  out  32  current F-stage PC, registered.
- npc  out  32  combinational next PC from npc_op (debug/trace).
- f_adel  out  1  fetch address fault, registered alongside f_pc.
- pend  out  1  pending redirect buffered.

Behaviour:
- Reset (reset=0, async): f_pc=RESET_PC, f_adel=(RESET_PC fault check), pend=0, pend_pc=0.

npc (combinational):
- PC4 → f_pc+4.
- BR → br_taken ? f_pc+(sext32(imm16)<<2) : f_pc+4.
- J → {d_pc[31:28], imm26, 2'b00}.
- JR → rs.
- ERET → epc.
- All adds are mod 2^32; overflow wraps silently.

Redirect:
- A redirect is npc_op ∈ {J, JR, ERET}, or npc_op = BR with br_taken = 1.

Register update each rising edge, first matching rule wins:
1. exc_req=1 → f_pc<=EXC_VEC, pend<=0. Ignores both stalls.
2. d_stall=1 → f_pc and pend hold. npc_op is ignored, because D re-presents it next cycle.
3. f_hold=1:
   - With a redirect: pend_pc<=npc, pend<=1. If a pending entry already exists, the newer target overwrites it.
   - f_pc holds in all f_hold cases.
4. f_hold=0, with a redirect → f_pc<=npc, pend<=0. A current redirect beats a stale pending entry.
5. f_hold=0, pend=1, no redirect → f_pc<=pend_pc, pend<=0.
6. Otherwise → f_pc<=npc (f_pc+4).

Fetch fault (f_adel):
- f_adel<=1 iff the next f_pc[1:0]!=0 or the next f_pc lies outside the fetch window. It is updated whenever f_pc is written and holds with it.
- The window test uses 33-bit arithmetic so IMEM_BASE+IMEM_SIZE cannot wrap.

Other rules:
- ERET has no delay slot; its redirect is taken at the same time as J/JR.
- Latency: a redirect presented in cycle n appears on f_pc at cycle n+1, or on the first cycle after f_hold falls.
- Reset asserted mid-operation discards any pending entry.

Test Plan:
- Reset release → f_pc=0x3000, f_adel=0; 3 cycles PC4 → 0x3004, 0x3008, 0x300C.
- f_pc=0x3010, BR, br_taken=1, imm16=0xFFFC → f_pc=0x3000; same with br_taken=0 → 0x3014.
- d_pc=0x3020, J, imm26=0x0000C40 → f_pc=0x3100. JR with rs=0x3202 → f_pc=0x3202, f_adel=1.
- f_hold=1 for 3 cycles, JR rs=0x3400 in cycle 1 only → pend=1 and f_pc frozen; after f_hold drops, f_pc=0x3400 and pend=0.
- Pending 0x3400, then exc_req=1 with f_hold=1 → f_pc=0x4180, pend=0. Simultaneous d_stall=1 with ERET epc=0x3008 → f_pc unchanged.
- reset pulsed low mid-cycle while pend=1 → f_pc=0x3000 immediately, pend=0. Then JR rs=0x7000 → f_adel=1.
